// File: rtl/pc_gen.sv
// Fetch-stage PC generator: holds the fetch PC, offers it to I-fetch with a
// valid/ready handshake, and steers the next PC from sequential advance, a
// branch redirect (deferred past an unfetched delay slot) or an exception.
module pc_gen #(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = 32'hBFC0_0000,
  parameter int unsigned     FETCH_WIDTH = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_valid_o,
  input  logic            pc_ready_i,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            br_ds_fetched_i,
  input  logic            exc_valid_i,
  input  logic [PC_W-1:0] exc_pc_i,
  output logic            addr_err_o
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_WAIT_DS = 1'b1;

  localparam logic [PC_W-1:0] STEP_WORD = PC_W'(4);
  localparam logic [PC_W-1:0] STEP_PAIR = PC_W'(8);

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            valid_q, valid_d;
  logic            addr_err_q, addr_err_d;

  logic            accept;
  logic [PC_W-1:0] seq_pc;

  // Handshake completes only when the offered PC is taken and the pipe is not stalled.
  assign accept = valid_q & pc_ready_i & ~stall_i;

  // Sequential successor; dual-issue fetch realigns to an 8-byte pair boundary.
  always_comb begin
    seq_pc = pc_q + STEP_WORD;
    if ((FETCH_WIDTH == 2) && !pc_q[2]) begin
      seq_pc = pc_q + STEP_PAIR;
    end
  end

  // Next-state / next-PC selection: exception > branch > delay-slot completion > sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    valid_d = 1'b1;

    if (exc_valid_i) begin
      pc_d    = exc_pc_i;
      state_d = ST_RUN;
      tgt_d   = '0;
    end else if (br_valid_i) begin
      if ((state_q == ST_RUN) && br_ds_fetched_i) begin
        pc_d = br_target_i;
      end else begin
        // Delay slot still to be fetched (or a new branch overwriting the held one).
        tgt_d   = br_target_i;
        state_d = ST_WAIT_DS;
        if (accept) begin
          pc_d = seq_pc;
        end
      end
    end else if (state_q == ST_WAIT_DS) begin
      if (accept) begin
        pc_d    = tgt_q;
        state_d = ST_RUN;
      end
    end else if (accept) begin
      pc_d = seq_pc;
    end

    addr_err_d = valid_d & (|pc_d[1:0]);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus a randomized run against a
// behavioural model; one single-issue and one dual-issue instance share stimulus.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        br_ds;
  logic        exc_valid;
  logic [31:0] exc_pc;

  logic [31:0] pc1, pc2;
  logic        v1, v2;
  logic        ae1, ae2;

  int vectors;
  int errors;

  // Model state, index 0 = single-issue, 1 = dual-issue.
  logic [31:0] m_pc [2];
  logic        m_valid [2];
  logic [31:0] m_pend [2][$];

  pc_gen #(.PC_W(32), .RESET_PC(RST_PC), .FETCH_WIDTH(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .pc_o(pc1), .pc_valid_o(v1), .pc_ready_i(ready),
    .stall_i(stall), .br_valid_i(br_valid), .br_target_i(br_target),
    .br_ds_fetched_i(br_ds), .exc_valid_i(exc_valid), .exc_pc_i(exc_pc),
    .addr_err_o(ae1)
  );

  pc_gen #(.PC_W(32), .RESET_PC(RST_PC), .FETCH_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .pc_o(pc2), .pc_valid_o(v2), .pc_ready_i(ready),
    .stall_i(stall), .br_valid_i(br_valid), .br_target_i(br_target),
    .br_ds_fetched_i(br_ds), .exc_valid_i(exc_valid), .exc_pc_i(exc_pc),
    .addr_err_o(ae2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ready = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    br_ds = 1'b0; exc_valid = 1'b0; exc_pc = '0;
  endtask

  // Force a PC via a one-cycle exception redirect.
  task automatic redirect(input logic [31:0] pc);
    exc_valid = 1'b1; exc_pc = pc;
    step();
    exc_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = RST_PC;
      m_valid[k] = 1'b0;
      m_pend[k].delete();
    end
  endtask

  // One clock of the architectural rules, applied to inputs seen at that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic        acc;
      logic [31:0] nxt;
      acc = m_valid[k] && ready && !stall;
      if (k == 1 && m_pc[k][2] == 1'b0) nxt = m_pc[k] + 32'd8;
      else                              nxt = m_pc[k] + 32'd4;
      if (exc_valid) begin
        m_pc[k] = exc_pc;
        m_pend[k].delete();
      end else if (br_valid) begin
        if (m_pend[k].size() == 0 && br_ds) begin
          m_pc[k] = br_target;
        end else begin
          m_pend[k].delete();
          m_pend[k].push_back(br_target);
          if (acc) m_pc[k] = nxt;
        end
      end else if (m_pend[k].size() != 0) begin
        if (acc) m_pc[k] = m_pend[k].pop_front();
      end else if (acc) begin
        m_pc[k] = nxt;
      end
      m_valid[k] = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'hBFC0_0000; exp_seq[1] = 32'hBFC0_0004;
    exp_seq[2] = 32'hBFC0_0008; exp_seq[3] = 32'hBFC0_000C;
    idle_inputs();
    rst_n = 1'b0;
    #13;
    vectors++;
    if (pc1 !== RST_PC || v1 !== 1'b0 || ae1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: pc=%h valid=%b aerr=%b, expected pc=%h valid=0 aerr=0", pc1, v1, ae1, RST_PC);
    end
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (pc1 !== exp_seq[i] || v1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_seq[%0d]: pc=%h valid=%b, expected pc=%h valid=1", i, pc1, v1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    step();
    vectors++;
    if (pc1 !== 32'hBFC0_0010) begin
      errors++;
      $display("FAIL bp_start: pc=%h, expected BFC00010", pc1);
    end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pc1 !== 32'hBFC0_0010 || v1 !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_low[%0d]: pc=%h valid=%b, expected BFC00010 valid=1", i, pc1, v1);
      end
    end
    ready = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pc1 !== 32'hBFC0_0010 || v1 !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: pc=%h valid=%b, expected BFC00010 valid=1", i, pc1, v1);
      end
    end
    stall = 1'b0;
    step();
    vectors++;
    if (pc1 !== 32'hBFC0_0014) begin
      errors++;
      $display("FAIL bp_resume: pc=%h, expected BFC00014", pc1);
    end
  endtask

  task automatic test_branch();
    ready = 1'b1;
    redirect(32'h0000_0100);
    br_valid = 1'b1; br_target = 32'h0000_0400; br_ds = 1'b1;
    step();
    br_valid = 1'b0;
    vectors++;
    if (pc1 !== 32'h0000_0400) begin
      errors++;
      $display("FAIL br_ds_fetched: pc=%h, expected 00000400", pc1);
    end
    redirect(32'h0000_0100);
    br_valid = 1'b1; br_ds = 1'b0;
    step();
    br_valid = 1'b0;
    vectors++;
    if (pc1 !== 32'h0000_0104) begin
      errors++;
      $display("FAIL br_ds_pending: pc=%h, expected 00000104", pc1);
    end
    ready = 1'b0;
    step();
    vectors++;
    if (pc1 !== 32'h0000_0104) begin
      errors++;
      $display("FAIL br_wait_hold: pc=%h, expected 00000104", pc1);
    end
    ready = 1'b1;
    step();
    vectors++;
    if (pc1 !== 32'h0000_0400) begin
      errors++;
      $display("FAIL br_wait_take: pc=%h, expected 00000400", pc1);
    end
    step();
    vectors++;
    if (pc1 !== 32'h0000_0404) begin
      errors++;
      $display("FAIL br_after: pc=%h, expected 00000404", pc1);
    end
  endtask

  task automatic test_exc_over_branch();
    ready = 1'b1;
    redirect(32'h0000_0100);
    ready = 1'b0;
    br_valid = 1'b1; br_target = 32'h0000_0400; br_ds = 1'b0;
    step();
    br_valid = 1'b0;
    exc_valid = 1'b1; exc_pc = 32'hBFC0_0380;
    br_valid = 1'b1; br_target = 32'h0000_0400;
    step();
    exc_valid = 1'b0; br_valid = 1'b0;
    vectors++;
    if (pc1 !== 32'hBFC0_0380) begin
      errors++;
      $display("FAIL exc_wins: pc=%h, expected BFC00380", pc1);
    end
    ready = 1'b1;
    step();
    step();
    vectors++;
    if (pc1 !== 32'hBFC0_0388) begin
      errors++;
      $display("FAIL exc_drops_target: pc=%h, expected BFC00388", pc1);
    end
  endtask

  task automatic test_dual_issue();
    logic [31:0] e1 [3];
    logic [31:0] e2 [3];
    e1[0] = 32'h104; e1[1] = 32'h108; e1[2] = 32'h10C;
    e2[0] = 32'h104; e2[1] = 32'h108; e2[2] = 32'h110;
    ready = 1'b1;
    redirect(32'h0000_0104);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pc1 !== e1[i] || pc2 !== e2[i]) begin
        errors++;
        $display("FAIL fw_seq[%0d]: pc1=%h pc2=%h, expected %h %h", i, pc1, pc2, e1[i], e2[i]);
      end
      if (i < 2) step();
    end
    redirect(32'hFFFF_FFF8);
    step();
    vectors++;
    if (pc2 !== 32'h0000_0000 || ae2 !== 1'b0) begin
      errors++;
      $display("FAIL fw2_wrap: pc=%h aerr=%b, expected 00000000 aerr=0", pc2, ae2);
    end
    redirect(32'hFFFF_FFFC);
    step();
    vectors++;
    if (pc1 !== 32'h0000_0000 || pc2 !== 32'h0000_0000) begin
      errors++;
      $display("FAIL fw_wrap4: pc1=%h pc2=%h, expected 00000000 00000000", pc1, pc2);
    end
    redirect(32'h0000_0200);
    ready = 1'b0;
    br_valid = 1'b1; br_target = 32'h0000_0600; br_ds = 1'b0;
    step();
    br_valid = 1'b0;
    ready = 1'b1;
    step();
    vectors++;
    if (pc2 !== 32'h0000_0600 || pc1 !== 32'h0000_0600) begin
      errors++;
      $display("FAIL fw_wait_take: pc1=%h pc2=%h, expected 00000600 00000600", pc1, pc2);
    end
  endtask

  task automatic test_misaligned();
    ready = 1'b1;
    redirect(32'h0000_0100);
    br_valid = 1'b1; br_target = 32'h0000_0402; br_ds = 1'b1;
    step();
    br_valid = 1'b0;
    vectors++;
    if (pc1 !== 32'h0000_0402 || ae1 !== 1'b1) begin
      errors++;
      $display("FAIL misalign_redirect: pc=%h aerr=%b, expected 00000402 aerr=1", pc1, ae1);
    end
    step();
    vectors++;
    if (pc1 !== 32'h0000_0406 || ae1 !== 1'b1) begin
      errors++;
      $display("FAIL misalign_advance: pc=%h aerr=%b, expected 00000406 aerr=1", pc1, ae1);
    end
    redirect(32'h0000_0100);
    vectors++;
    if (ae1 !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: aerr=%b, expected 0", ae1);
    end
    ready = 1'b0;
    br_valid = 1'b1; br_target = 32'h0000_0500; br_ds = 1'b0;
    step();
    br_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pc1 !== RST_PC || v1 !== 1'b0 || ae1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h valid=%b aerr=%b, expected %h 0 0", pc1, v1, ae1, RST_PC);
    end
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    step();
    vectors++;
    if (pc1 !== 32'hBFC0_0004 || v1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_drops_target: pc=%h valid=%b, expected BFC00004 1", pc1, v1);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    model_reset();
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      ready     = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 6) == 0);
      br_valid  = ($urandom_range(0, 7) == 0);
      br_ds     = $urandom_range(0, 1) == 1;
      br_target = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) br_target = br_target | 32'($urandom_range(1, 3));
      exc_valid = ($urandom_range(0, 24) == 0);
      exc_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      step();
      model_step();
      vectors++;
      if (pc1 !== m_pc[0] || v1 !== m_valid[0] || ae1 !== (m_valid[0] & (|m_pc[0][1:0]))) begin
        errors++;
        $display("FAIL rand_fw1[%0d]: pc=%h valid=%b aerr=%b, expected pc=%h valid=%b", n, pc1, v1, ae1, m_pc[0], m_valid[0]);
      end
      vectors++;
      if (pc2 !== m_pc[1] || v2 !== m_valid[1] || ae2 !== (m_valid[1] & (|m_pc[1][1:0]))) begin
        errors++;
        $display("FAIL rand_fw2[%0d]: pc=%h valid=%b aerr=%b, expected pc=%h valid=%b", n, pc2, v2, ae2, m_pc[1], m_valid[1]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_backpressure();
    test_branch();
    test_exc_over_branch();
    test_dual_issue();
    test_misaligned();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
